// File: rtl/stage_ram_arbiter.sv
// Time-slices the single-port stage RAM between the VGA pixel fetch (phase 0)
// and a game-logic req/ack port (phase 1, plus any phase-0 slot video does not need).
module stage_ram_arbiter #(
    parameter int unsigned STAGE_W = 208,
    parameter int unsigned STAGE_H = 240,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              vid_active,
    output logic [DATA_W-1:0] vid_color_index,
    input  logic              lg_req,
    input  logic              lg_we,
    input  logic [7:0]        lg_x,
    input  logic [7:0]        lg_y,
    input  logic [DATA_W-1:0] lg_wdata,
    output logic              lg_ack,
    output logic [DATA_W-1:0] lg_rdata,
    output logic              lg_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {L_IDLE, L_ISSUE, L_RDWAIT, L_DONE} lg_state_e;

    localparam logic [31:0] STRIDE = 32'(STAGE_W);

    // Constant multiply by the row stride as a sum of shifted copies of y.
    function automatic logic [ADDR_W-1:0] row_base(input logic [9:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (STRIDE[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    lg_state_e         state_q, state_d;
    logic              phase_q, phase_d;
    logic              we_q, we_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              vid_fetch_q, vid_fetch_d;
    logic              vid_hit_q, vid_hit_d;
    logic [DATA_W-1:0] vid_color_q, vid_color_d;

    logic vid_in_range_c;
    logic lg_slot_c;
    logic lg_oor_c;

    always_comb begin
        vid_in_range_c = vid_active && (32'(DrawX) < STAGE_W) && (32'(DrawY) < STAGE_H);
        lg_slot_c      = phase_q || !vid_in_range_c;
        lg_oor_c       = (32'(lg_x) >= STAGE_W) || (32'(lg_y) >= STAGE_H);

        state_d     = state_q;
        phase_d     = !phase_q;
        we_d        = we_q;
        x_d         = x_q;
        y_d         = y_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        vid_fetch_d = !phase_q;
        vid_hit_d   = !phase_q && vid_in_range_c;
        vid_color_d = vid_color_q;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;

        // Video result lands one cycle after the RAM's registered read.
        if (vid_fetch_q) vid_color_d = vid_hit_q ? ram_rdata : '0;

        if (!phase_q && vid_in_range_c) begin
            ram_addr = row_base(DrawY) + ADDR_W'(DrawX);
        end

        unique case (state_q)
            L_IDLE: begin
                if (lg_req) begin
                    we_d    = lg_we;
                    x_d     = lg_x;
                    y_d     = lg_y;
                    wdata_d = lg_wdata;
                    err_d   = lg_oor_c;
                    if (lg_oor_c) begin
                        rdata_d = '0;
                        state_d = L_DONE;
                    end else begin
                        state_d = L_ISSUE;
                    end
                end
            end
            L_ISSUE: begin
                if (lg_slot_c) begin
                    ram_addr  = row_base(10'(y_q)) + ADDR_W'(x_q);
                    ram_we    = we_q;
                    ram_wdata = we_q ? wdata_q : '0;
                    state_d   = we_q ? L_DONE : L_RDWAIT;
                end
            end
            L_RDWAIT: begin
                rdata_d = ram_rdata;
                state_d = L_DONE;
            end
            L_DONE: begin
                state_d = L_IDLE;
            end
        endcase

        // Keep the port quiet during reset so an abandoned write never lands.
        if (Reset) begin
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= L_IDLE;
            phase_q     <= 1'b0;
            we_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            vid_fetch_q <= 1'b0;
            vid_hit_q   <= 1'b0;
            vid_color_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            we_q        <= we_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            vid_fetch_q <= vid_fetch_d;
            vid_hit_q   <= vid_hit_d;
            vid_color_q <= vid_color_d;
        end
    end

    assign vid_color_index = vid_color_q;
    assign lg_rdata        = rdata_q;
    assign lg_ack          = (state_q == L_DONE) && !Reset;
    assign lg_err          = lg_ack && err_q;

endmodule

// File: tb/tb_stage_ram_arbiter.sv
// Randomized scoreboard bench for stage_ram_arbiter with a behavioural RAM and slot model.
module tb_stage_ram_arbiter;

    localparam int SW = 208;
    localparam int SH = 240;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        vid_active;
    logic [1:0]  vid_color_index;
    logic        lg_req, lg_we;
    logic [7:0]  lg_x, lg_y;
    logic [1:0]  lg_wdata;
    logic        lg_ack, lg_err;
    logic [1:0]  lg_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [1:0]  ram_wdata;
    logic [1:0]  ram_rdata;

    stage_ram_arbiter dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vid_active(vid_active),
        .vid_color_index(vid_color_index), .lg_req(lg_req), .lg_we(lg_we), .lg_x(lg_x),
        .lg_y(lg_y), .lg_wdata(lg_wdata), .lg_ack(lg_ack), .lg_rdata(lg_rdata),
        .lg_err(lg_err), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic        we;
        logic        err;
        logic [15:0] addr;
        logic [1:0]  wdata;
        logic [1:0]  rdata;
        int          acc_cyc;
        int          lmin;
        int          lmax;
    } sb_item_t;

    sb_item_t   sb_q[$];
    logic [1:0] vq[$];
    logic [1:0] mem     [0:65535];
    logic [1:0] ref_mem [0:65535];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         wr_count = 0;
    int         exp_wr = 0;
    logic       tb_phase = 1'b0;
    logic [1:0] last_rd = 2'b0;
    int         vid_mode = 0;
    logic [9:0] fix_x = '0, fix_y = '0;

    function automatic logic [1:0] init_val(input int i);
        if (i == 421) return 2'd3;
        return 2'(i * 7 + i / 13);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        tb_phase <= Reset ? 1'b0 : !tb_phase;
    end

    // Behavioural single-port RAM: registered read, read-before-write.
    initial begin
        ram_rdata = 2'b0;
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        forever begin
            @(posedge Clk);
            ram_rdata <= mem[ram_addr];
            if (ram_we) begin
                mem[ram_addr] = ram_wdata;
                wr_count++;
            end
        end
    end

    // Raster driver: 0 = blanking, 1 = fixed pixel, 2 = random pixel.
    initial begin
        vid_active = 1'b0; DrawX = '0; DrawY = '0;
        forever begin
            @(posedge Clk); #1;
            case (vid_mode)
                1: begin vid_active = 1'b1; DrawX = fix_x; DrawY = fix_y; end
                2: begin
                    vid_active = ($urandom_range(0, 3) != 0);
                    DrawX = 10'($urandom_range(0, 260));
                    DrawY = 10'($urandom_range(100, 300));
                end
                default: begin vid_active = 1'b0; DrawX = '0; DrawY = '0; end
            endcase
        end
    end

    // Monitor: video pipeline, slot ownership and logic acks against the model.
    initial begin
        bit         primed;
        bit         vin;
        int         vaddr;
        int         lat;
        sb_item_t   it;
        primed = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                vq.delete();
                primed = 0;
            end else begin
                if (!primed) begin
                    vq.push_back(2'b0);
                    vq.push_back(2'b0);
                    primed = 1;
                end
                vin   = vid_active && (int'(DrawX) < SW) && (int'(DrawY) < SH);
                vaddr = int'(DrawY) * SW + int'(DrawX);
                if (!tb_phase) vq.push_back(vin ? ref_mem[vaddr] : 2'b0);
                else           vq.push_back(vq[$]);
                chk("vid_color", 32'(vid_color_index), 32'(vq.pop_front()));
                if (!tb_phase && vin)
                    chk("vid_slot", {15'b0, ram_we, ram_addr}, {15'b0, 1'b0, 16'(vaddr)});
                if (ram_we) begin
                    chk("we_slot", 32'(tb_phase || !vin), 32'd1);
                    if (sb_q.size() == 0) chk("wr_unexpected", 32'(ram_we), 32'd0);
                    else chk("wr_port", {13'b0, sb_q[0].we, ram_addr, ram_wdata},
                             {13'b0, 1'b1, sb_q[0].addr, sb_q[0].wdata});
                end
                chk("err_wo_ack", 32'(lg_err && !lg_ack), 32'd0);
                if (lg_ack) begin
                    if (sb_q.size() == 0) chk("ack_unexpected", 32'(lg_ack), 32'd0);
                    else begin
                        it  = sb_q.pop_front();
                        lat = cyc - it.acc_cyc;
                        total++;
                        if (lat < it.lmin || lat > it.lmax) begin
                            bad++;
                            $display("FAIL ack_lat act=%0d required=%0d..%0d cyc=%0d",
                                     lat, it.lmin, it.lmax, cyc);
                        end
                        chk("ack_err", 32'(lg_err), 32'(it.err));
                        chk("ack_rdata", 32'(lg_rdata), 32'(it.rdata));
                    end
                end
            end
        end
    end

    task automatic do_txn(input logic we, input logic [7:0] x, input logic [7:0] y,
                          input logic [1:0] wd, input bit drop);
        sb_item_t it;
        bit       got;
        bit       blank;
        blank      = (vid_mode == 0);
        it.we      = we;
        it.err     = (int'(x) >= SW) || (int'(y) >= SH);
        it.addr    = 16'(int'(y) * SW + int'(x));
        it.wdata   = wd;
        it.acc_cyc = cyc;
        if (it.err) begin
            it.lmin = 1; it.lmax = 1; last_rd = 2'b0;
        end else if (we) begin
            it.lmin = 2; it.lmax = blank ? 2 : 3;
            ref_mem[it.addr] = wd;
            exp_wr++;
        end else begin
            it.lmin = 3; it.lmax = blank ? 3 : 4;
            last_rd = ref_mem[it.addr];
        end
        it.rdata = last_rd;
        sb_q.push_back(it);
        lg_req = 1'b1; lg_we = we; lg_x = x; lg_y = y; lg_wdata = wd;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge Clk); #1;
            if (drop) lg_req = 1'b0;
            if (lg_ack) got = 1;
        end
        lg_req = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout act=no_ack exp=ack x=%0d y=%0d", x, y);
            sb_q.delete();
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        int wr_before;
        Reset = 1'b1; lg_req = 1'b0; lg_we = 1'b0; lg_x = '0; lg_y = '0; lg_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_vid", 32'(vid_color_index), 32'd0);
        chk("rst_ack", {30'b0, lg_ack, lg_err}, 32'd0);
        chk("rst_rdata", 32'(lg_rdata), 32'd0);
        chk("rst_port", {13'b0, ram_we, ram_addr, ram_wdata}, 32'd0);
        @(posedge Clk); #1;

        fix_x = 10'd5; fix_y = 10'd2; vid_mode = 1;
        repeat (8) @(posedge Clk);
        #1;

        do_txn(1'b1, 8'd10, 8'd1, 2'd2, 1'b0);
        do_txn(1'b0, 8'd10, 8'd1, 2'd0, 1'b0);

        vid_mode = 0;
        repeat (3) @(posedge Clk);
        #1;
        do_txn(1'b0, 8'd10, 8'd1, 2'd0, 1'b0);
        do_txn(1'b1, 8'd50, 8'd60, 2'd1, 1'b0);
        do_txn(1'b0, 8'd207, 8'd239, 2'd0, 1'b0);

        do_txn(1'b0, 8'd208, 8'd0, 2'd0, 1'b0);
        do_txn(1'b1, 8'd0, 8'd240, 2'd3, 1'b0);
        do_txn(1'b0, 8'd255, 8'd255, 2'd0, 1'b0);

        vid_mode = 1;
        repeat (2) @(posedge Clk);
        #1;
        wr_before = wr_count;
        lg_req = 1'b1; lg_we = 1'b1; lg_x = 8'd20; lg_y = 8'd3;
        lg_wdata = 2'(init_val(644) + 2'd1);
        @(posedge Clk); #1;
        Reset = 1'b1; lg_req = 1'b0; last_rd = 2'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("abort_we", 32'(wr_count), 32'(wr_before));
        chk("abort_mem", 32'(mem[644]), 32'(ref_mem[644]));

        vid_mode = 2;
        repeat (2) @(posedge Clk);
        #1;
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 215)),
                   8'($urandom_range(0, 99)), 2'($urandom_range(0, 3)), n == 7);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end

        vid_mode = 0;
        repeat (6) @(posedge Clk);
        #1;
        chk("wr_count", 32'(wr_count), 32'(exp_wr));
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_ram_arbiter.md
Name: stage_ram_arbiter

Overview:
- Shares the single-port stage RAM between two requesters: the VGA pixel fetch path feeding color_mapper, and game-logic tile lookups/updates (collision checks, ladder/floor edits).
- Computes linear RAM addresses from (x,y) and time-slices the RAM port so both requesters get service.
- Gives video bounded, deterministic latency.
- Gives the logic requester a req/ack handshake with bounded wait.

Parameters:
STAGE_W, 208, stage width in pixels; row stride of the RAM.
STAGE_H, 240, stage height in pixels.
ADDR_W, 16, RAM address width; STAGE_W*STAGE_H must be <= 2^ADDR_W.
DATA_W, 2, colour-index width per pixel.

Ports:
Clk  in  1  system clock (50 MHz).
Reset  in  1  synchronous, active-high reset.
DrawX  in  10  current raster X from vga_controller.
DrawY  in  10  current raster Y from vga_controller.
vid_active  in  1  high while raster is in the visible area.
vid_color_index  out  DATA_W  stage colour index for the pixel sampled 2 cycles earlier.
lg_req  in  1  logic access request; held until lg_ack.
lg_we  in  1  1=write, 0=read; sampled at accept.
lg_x  in  8  logic pixel X; sampled at accept.
lg_y  in  8  logic pixel Y; sampled at accept.
lg_wdata  in  DATA_W  write data; sampled at accept.
lg_ack  out  1  one-cycle completion pulse.
lg_rdata  out  DATA_W  read result; valid with lg_ack, held until next ack.
lg_err  out  1  pulses with lg_ack when the coordinate is out of range.
ram_addr  out  ADDR_W  RAM address.
ram_we  out  1  RAM write enable.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency.

Behaviour:
- Reset: all outputs 0; slot phase = 0; logic FSM = L_IDLE; internal pipelines cleared.
- Slot phase: a toggle bit flips every cycle.
  - Phase 0 is the video slot; phase 1 is the logic slot.
  - If the video pixel is not in range (vid_active=0, DrawX>=STAGE_W or DrawY>=STAGE_H), the phase-0 slot is also available to logic.
- Video path, phase 0 and in range:
  - ram_addr = DrawY*STAGE_W + DrawX, truncated to ADDR_W; ram_we=0.
  - The multiply is done as shift-add; for the default 208 this is (y<<7)+(y<<6)+(y<<4).
  - vid_color_index is registered from ram_rdata exactly 2 cycles after the slot.
  - An out-of-range pixel yields vid_color_index=0 at the same 2-cycle latency.
  - Between fetches vid_color_index holds its value.
- Logic FSM states: L_IDLE, L_ISSUE, L_RDWAIT, L_DONE.
- L_IDLE:
  - lg_req=1 latches we/x/y/wdata.
  - If lg_x>=STAGE_W or lg_y>=STAGE_H, go to L_DONE with err flagged and no RAM access.
  - Otherwise go to L_ISSUE.
- L_ISSUE:
  - Waits for an available slot, then drives ram_addr=y*STAGE_W+x, ram_we=we, ram_wdata=wdata.
  - Write: go to L_DONE.
  - Read: go to L_RDWAIT.
- L_RDWAIT: captures ram_rdata into lg_rdata, then goes to L_DONE.
- L_DONE:
  - lg_ack=1 for exactly one cycle.
  - lg_err=1 that cycle if out of range; in that case lg_rdata=0.
  - Returns to L_IDLE.
  - A new request is not accepted in the L_DONE cycle; earliest re-accept is the following cycle.
- Latency from accept to ack:
  - Write: 2–3 cycles.
  - Read: 3–4 cycles.
  - Out of range: 1 cycle.
  - Never exceeds these bounds, regardless of video load.
- ram_we is 0 in every cycle except a logic write issue. Video and logic never drive the port in the same cycle.
- lg_req dropping before ack is a protocol violation; the transaction still completes and acks.
- Reset mid-transaction: the transaction is abandoned with no ack and no RAM write after the reset cycle; state returns to reset values.

Test Plan:
1. Reset held 3 cycles, then released with vid_active=0 -> all outputs 0; first ram_we never asserted.
2. Video: vid_active=1, DrawX=5, DrawY=2, RAM preloaded addr 421=2'b11 -> ram_addr=421 on phase-0 slot; vid_color_index=3 two cycles later.
3. Logic write x=10,y=1,wdata=2 during active video, then read same -> write address 218 issued only on phase-1 slot; ack within 3 cycles; read ack within 4 cycles with lg_rdata=2.
4. Logic read during blanking (vid_active=0) -> issued on the next cycle regardless of phase; ack after 3 cycles.
5. lg_x=208, lg_y=0 -> ack and lg_err 1 cycle after accept; lg_rdata=0; no RAM access.
6. Reset asserted in L_ISSUE of a write -> no ram_we pulse after reset; no lg_ack; RAM contents unchanged.
